// File: rtl/reaction_timer_ctrl.sv
// Multi-player reaction-game controller: arm delay, GO window with timeout, false-start and winner reporting.
// Optional random extra arm delay from a Galois LFSR, enabled by defining RANDOM_DELAY_EN.
module reaction_timer_ctrl #(
    parameter int N_PLAYERS  = 2,
    parameter int TIME_W     = 10,
    parameter int WAIT_MS    = 5000,
    parameter int TIMEOUT_MS = 1000,
    parameter int RAND_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_ms,
    input  logic                 start,
    input  logic                 clear,
    input  logic [N_PLAYERS-1:0] buttons,
    output logic [2:0]           state_out,
    output logic                 led_go,
    output logic [TIME_W-1:0]    reaction_ms,
    output logic [N_PLAYERS-1:0] winner,
    output logic [N_PLAYERS-1:0] false_start,
    output logic                 done
);
    localparam int WAIT_W = $clog2(WAIT_MS + (1 << RAND_W)) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_ARMED   = 3'b001,
        S_GO      = 3'b010,
        S_FOUL    = 3'b011,
        S_RESULT  = 3'b100,
        S_TIMEOUT = 3'b101
    } state_t;

    state_t                 state_reg, state_next;
    logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next, wait_inc, target;
    logic [TIME_W-1:0]      react_cnt_reg, react_cnt_next, react_inc;
    logic [TIME_W-1:0]      reaction_reg, reaction_next;
    logic [N_PLAYERS-1:0]   winner_reg, winner_next;
    logic [N_PLAYERS-1:0]   false_start_reg, false_start_next;
    logic [N_PLAYERS-1:0]   buttons_d_reg, edges, first_edge;
    logic [N_PLAYERS:0]     seen;
    logic                   led_go_reg, done_reg;

`ifdef RANDOM_DELAY_EN
    function automatic logic [RAND_W-1:0] lfsr_mask(input int w);
        logic [31:0] m;
        case (w)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            default: m = 32'h0000_D008;
        endcase
        return m[RAND_W-1:0];
    endfunction

    localparam logic [RAND_W-1:0] LFSR_MASK = lfsr_mask(RAND_W);

    logic [RAND_W-1:0] lfsr_reg;
    logic [WAIT_W-1:0] target_reg;

    // Free-running right-shift Galois LFSR; the round's extra delay is its value when the round arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg   <= RAND_W'(1);
            target_reg <= '0;
        end else begin
            lfsr_reg <= {1'b0, lfsr_reg[RAND_W-1:1]} ^ (lfsr_reg[0] ? LFSR_MASK : '0);
            if (state_reg == S_IDLE && state_next == S_ARMED)
                target_reg <= WAIT_W'(WAIT_MS) + WAIT_W'(lfsr_reg);
        end
    end

    assign target = target_reg;
`else
    assign target = WAIT_W'(WAIT_MS);
`endif

    // Rising-edge detect, then keep only the lowest-index player that has an edge.
    assign edges   = buttons & ~buttons_d_reg;
    assign seen[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_first
            assign first_edge[gi] = edges[gi] & ~seen[gi];
            assign seen[gi+1]     = seen[gi] | edges[gi];
        end
    endgenerate

    assign wait_inc  = wait_cnt_reg + WAIT_W'(1);
    assign react_inc = react_cnt_reg + TIME_W'(1);

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        react_cnt_next   = react_cnt_reg;
        reaction_next    = reaction_reg;
        winner_next      = winner_reg;
        false_start_next = false_start_reg;
        if (clear) begin
            state_next       = S_IDLE;
            wait_cnt_next    = '0;
            react_cnt_next   = '0;
            reaction_next    = '0;
            winner_next      = '0;
            false_start_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    wait_cnt_next  = '0;
                    react_cnt_next = '0;
                    if (start)
                        state_next = S_ARMED;
                end
                S_ARMED: begin
                    if (!start) begin
                        state_next = S_IDLE;
                    end else if (|buttons) begin
                        state_next       = S_FOUL;
                        false_start_next = buttons;
                    end else if (tick_ms) begin
                        if (wait_cnt_reg != '1)
                            wait_cnt_next = wait_inc;
                        if (wait_inc == target)
                            state_next = S_GO;
                    end
                end
                S_GO: begin
                    if (!start) begin
                        state_next = S_IDLE;
                    end else begin
                        if (tick_ms && react_cnt_reg != TIME_W'(TIMEOUT_MS))
                            react_cnt_next = react_inc;
                        // A press wins over a timeout landing on the same tick.
                        if (|edges) begin
                            state_next    = S_RESULT;
                            winner_next   = first_edge;
                            reaction_next = react_cnt_reg;
                        end else if (tick_ms && react_inc == TIME_W'(TIMEOUT_MS)) begin
                            state_next = S_TIMEOUT;
                        end
                    end
                end
                S_RESULT, S_FOUL, S_TIMEOUT: begin
                    state_next = state_reg;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            wait_cnt_reg    <= '0;
            react_cnt_reg   <= '0;
            reaction_reg    <= '0;
            winner_reg      <= '0;
            false_start_reg <= '0;
            buttons_d_reg   <= '0;
            led_go_reg      <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            react_cnt_reg   <= react_cnt_next;
            reaction_reg    <= reaction_next;
            winner_reg      <= winner_next;
            false_start_reg <= false_start_next;
            buttons_d_reg   <= buttons;
            led_go_reg      <= (state_next == S_GO);
            done_reg        <= (state_next == S_RESULT) || (state_next == S_FOUL)
                               || (state_next == S_TIMEOUT);
        end
    end

    assign state_out   = state_reg;
    assign led_go      = led_go_reg;
    assign done        = done_reg;
    assign reaction_ms = reaction_reg;
    assign winner      = winner_reg;
    assign false_start = false_start_reg;
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl: a table of single-cycle vectors plus multi-cycle round sequences.
// Define RANDOM_DELAY_EN to exercise the random arm delay against a reference LFSR.
module tb_reaction_timer_ctrl;
    localparam logic [2:0] IDLE = 3'b000, ARMED = 3'b001, GO = 3'b010,
                           FOUL = 3'b011, RESULT = 3'b100, TMO = 3'b101;

    logic       clk = 1'b0;
    logic       rst, tick_ms, start, clear;
    logic [1:0] buttons;
    logic [2:0] state_out;
    logic       led_go, done;
    logic [9:0] reaction_ms;
    logic [1:0] winner, false_start;

    int n_vec = 0;
    int n_bad = 0;

    reaction_timer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick_ms    (tick_ms),
        .start      (start),
        .clear      (clear),
        .buttons    (buttons),
        .state_out  (state_out),
        .led_go     (led_go),
        .reaction_ms(reaction_ms),
        .winner     (winner),
        .false_start(false_start),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       clear;
        logic       tick;
        logic [1:0] buttons;
        logic [2:0] st;
        logic       led;
        logic [9:0] rms;
        logic [1:0] win;
        logic [1:0] fs;
        logic       dn;
    } vec_t;

    vec_t vt[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick_ms = 1'b1;
        repeat (n) step();
        tick_ms = 1'b0;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic led,
                         input logic [9:0] rms, input logic [1:0] win,
                         input logic [1:0] fs, input logic dn);
        n_vec++;
        if ({state_out, led_go, reaction_ms, winner, false_start, done} !== {st, led, rms, win, fs, dn}) begin
            n_bad++;
            $display("FAIL %s: got state=%b led=%b rms=%0d win=%b fs=%b done=%b, want state=%b led=%b rms=%0d win=%b fs=%b done=%b",
                     name, state_out, led_go, reaction_ms, winner, false_start, done,
                     st, led, rms, win, fs, dn);
        end else begin
            $display("ok   %s: state=%b led=%b rms=%0d win=%b fs=%b done=%b",
                     name, state_out, led_go, reaction_ms, winner, false_start, done);
        end
    endtask

    task automatic clear_to_idle(input string name);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check(name, IDLE, 0, 0, 2'b00, 2'b00, 0);
    endtask

    // Arm a round and run the 5000-tick delay; lands in GO.
    task automatic go_round(input string name);
        start = 1'b1;
        step();
        ticks(5000);
        check(name, GO, 1, 0, 2'b00, 2'b00, 0);
    endtask

`ifdef RANDOM_DELAY_EN
    logic [9:0] m_lfsr;
    always @(posedge clk) begin
        if (rst)
            m_lfsr <= 10'd1;
        else
            m_lfsr <= {1'b0, m_lfsr[9:1]} ^ (m_lfsr[0] ? 10'h240 : 10'h000);
    end
`endif

    initial begin
        rst = 1'b1; tick_ms = 1'b0; start = 1'b0; clear = 1'b0; buttons = 2'b00;
        step();
        step();
        rst = 1'b0;
        check("reset", IDLE, 0, 0, 2'b00, 2'b00, 0);

        //            start clr tick btn    state  led rms win    fs     dn
        vt[0]  = '{1'b0, 1'b0, 1'b1, 2'b01, IDLE,  1'b0, 10'd0, 2'b00, 2'b00, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, ARMED, 1'b0, 10'd0, 2'b00, 2'b00, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 2'b00, ARMED, 1'b0, 10'd0, 2'b00, 2'b00, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 2'b00, IDLE,  1'b0, 10'd0, 2'b00, 2'b00, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, ARMED, 1'b0, 10'd0, 2'b00, 2'b00, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 2'b01, FOUL,  1'b0, 10'd0, 2'b00, 2'b01, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, FOUL,  1'b0, 10'd0, 2'b00, 2'b01, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 2'b11, FOUL,  1'b0, 10'd0, 2'b00, 2'b01, 1'b1};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 2'b00, IDLE,  1'b0, 10'd0, 2'b00, 2'b00, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 2'b11, ARMED, 1'b0, 10'd0, 2'b00, 2'b00, 1'b0};
        vt[10] = '{1'b1, 1'b0, 1'b0, 2'b11, FOUL,  1'b0, 10'd0, 2'b00, 2'b11, 1'b1};
        vt[11] = '{1'b0, 1'b1, 1'b0, 2'b00, IDLE,  1'b0, 10'd0, 2'b00, 2'b00, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b0, 2'b10, IDLE,  1'b0, 10'd0, 2'b00, 2'b00, 1'b0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 2'b00, IDLE,  1'b0, 10'd0, 2'b00, 2'b00, 1'b0};

        for (int i = 0; i < 14; i++) begin
            start = vt[i].start; clear = vt[i].clear;
            tick_ms = vt[i].tick; buttons = vt[i].buttons;
            step();
            check($sformatf("vec%0d", i), vt[i].st, vt[i].led, vt[i].rms,
                  vt[i].win, vt[i].fs, vt[i].dn);
        end
        start = 1'b0; clear = 1'b0; tick_ms = 1'b0; buttons = 2'b00;

`ifndef RANDOM_DELAY_EN
        // GO exactly on the 5000th tick, then a win at reaction count 37
        start = 1'b1;
        step();
        check("t1_armed", ARMED, 0, 0, 2'b00, 2'b00, 0);
        ticks(4999);
        check("t1_tick4999", ARMED, 0, 0, 2'b00, 2'b00, 0);
        ticks(1);
        check("t1_go", GO, 1, 0, 2'b00, 2'b00, 0);
        ticks(37);
        check("t2_go37", GO, 1, 0, 2'b00, 2'b00, 0);
        buttons = 2'b01;
        step();
        buttons = 2'b00;
        check("t2_result", RESULT, 0, 37, 2'b01, 2'b00, 1);
        buttons = 2'b10;
        step();
        check("t2_press_after", RESULT, 0, 37, 2'b01, 2'b00, 1);
        buttons = 2'b00; start = 1'b0;
        step();
        check("t2_start_low", RESULT, 0, 37, 2'b01, 2'b00, 1);
        clear_to_idle("t5_clear_result");

        // False start after 1200 ticks
        start = 1'b1;
        step();
        ticks(1200);
        check("t3_armed1200", ARMED, 0, 0, 2'b00, 2'b00, 0);
        buttons = 2'b10;
        step();
        buttons = 2'b00;
        check("t3_foul", FOUL, 0, 0, 2'b00, 2'b10, 1);
        clear_to_idle("t3_clear");

        // Simultaneous presses: lowest index wins
        go_round("t4a_go");
        ticks(12);
        buttons = 2'b11;
        step();
        buttons = 2'b00;
        check("t4a_tie", RESULT, 0, 12, 2'b01, 2'b00, 1);
        clear_to_idle("t4a_clear");

        // No press: timeout on the 1000th tick
        go_round("t4b_go");
        ticks(999);
        check("t4b_tick999", GO, 1, 0, 2'b00, 2'b00, 0);
        ticks(1);
        check("t4b_timeout", TMO, 0, 0, 2'b00, 2'b00, 1);
        clear_to_idle("t4b_clear");

        // Press on the same tick as the timeout: press wins with the pre-tick count
        go_round("t4c_go");
        ticks(999);
        tick_ms = 1'b1; buttons = 2'b01;
        step();
        tick_ms = 1'b0; buttons = 2'b00;
        check("t4c_edge_vs_timeout", RESULT, 0, 999, 2'b01, 2'b00, 1);
        clear_to_idle("t4c_clear");

        // Player 1 alone, immediately in GO
        go_round("t4d_go");
        buttons = 2'b10;
        step();
        buttons = 2'b00;
        check("t4d_p1", RESULT, 0, 0, 2'b10, 2'b00, 1);
        clear_to_idle("t4d_clear");

        // Abort from GO, then reset from GO
        go_round("t5_go_abort");
        ticks(3);
        start = 1'b0;
        step();
        check("t5_abort_go", IDLE, 0, 0, 2'b00, 2'b00, 0);
        go_round("t5_go_rst");
        ticks(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_go", IDLE, 0, 0, 2'b00, 2'b00, 0);
`else
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            int exp_ticks;
            int cnt;
            exp_ticks = 5000 + int'(m_lfsr);
            start = 1'b1;
            step();
            cnt = 0;
            tick_ms = 1'b1;
            while (state_out != GO && cnt < 6200) begin
                step();
                cnt++;
            end
            tick_ms = 1'b0;
            n_vec++;
            if (cnt != exp_ticks || exp_ticks == 5000) begin
                n_bad++;
                $display("FAIL rnd%0d_delay: got %0d ticks, want %0d", r, cnt, exp_ticks);
            end else begin
                $display("ok   rnd%0d_delay: %0d ticks", r, cnt);
            end
            check($sformatf("rnd%0d_go", r), GO, 1, 0, 2'b00, 2'b00, 0);
            start = 1'b0;
            step();
            check($sformatf("rnd%0d_abort", r), IDLE, 0, 0, 2'b00, 2'b00, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
